// File: rtl/serial_transmitter_if.sv
`timescale 1ns/1ps
// Transmit-side handshake bundle for serial_transmitter.
// master: drives load/data_in, observes data_out/busy/charSent.
// slave : the transmitter itself (consumes load/data_in, drives line and status).
interface serial_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic                 load;
  logic [DATA_BITS-1:0] data_in;
  logic                 data_out;
  logic                 busy;
  logic                 charSent;

  modport master (
    output load,
    output data_in,
    input  data_out,
    input  busy,
    input  charSent
  );

  modport slave (
    input  load,
    input  data_in,
    output data_out,
    output busy,
    output charSent
  );
endinterface

// File: rtl/serial_transmitter.sv
`timescale 1ns/1ps
// Async serial transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, stop bit.
// Latency: line drops to the start bit on the same edge load is accepted; each bit lasts SAMPLES_PER_BIT cycles.
// Backpressure: load is only honoured in IDLE (busy=0); requests while busy are dropped, not queued.
// Ports: clk, reset (sync, active-high), tx (slave modport: load, data_in -> data_out, busy, charSent).
// Optional feature: define TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_transmitter #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_transmitter_if.slave  tx
);

  localparam int SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] SAMPLE_MAX = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sample_count_q, sample_count_d;
  logic [BW-1:0]         bit_count_q, bit_count_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  data_out_q, data_out_d;
  logic                  busy_q, busy_d;
  logic                  char_sent_q, char_sent_d;
`ifdef TX_PARITY_EN
  // Parity is taken from the character at load time, since the shift register is consumed as bits go out.
  logic                  parity_q, parity_d;
`endif

  logic sample_wrap;

  always_comb begin
    state_d        = state_q;
    sample_count_d = sample_count_q;
    bit_count_d    = bit_count_q;
    shift_d        = shift_q;
    data_out_d     = data_out_q;
    busy_d         = busy_q;
    char_sent_d    = 1'b0;
`ifdef TX_PARITY_EN
    parity_d       = parity_q;
`endif

    sample_wrap = (sample_count_q == SAMPLE_MAX);

    // Outside IDLE the sample counter free-runs and wraps once per bit period.
    if (state_q != IDLE) begin
      sample_count_d = sample_wrap ? '0 : sample_count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        data_out_d = 1'b1;
        busy_d     = 1'b0;
        if (tx.load) begin
          shift_d        = tx.data_in;
`ifdef TX_PARITY_EN
          parity_d       = ^tx.data_in;
`endif
          sample_count_d = '0;
          bit_count_d    = '0;
          state_d        = START;
          // Registered output: the start bit appears on the accepting edge itself.
          data_out_d     = 1'b0;
          busy_d         = 1'b1;
        end
      end

      START: begin
        if (sample_wrap) begin
          state_d    = DATA;
          data_out_d = shift_q[0];
        end
      end

      DATA: begin
        if (sample_wrap) begin
          shift_d     = shift_q >> 1;
          bit_count_d = bit_count_q + 1'b1;
          data_out_d  = shift_d[0];
          if (bit_count_q == BIT_MAX) begin
            bit_count_d = '0;
`ifdef TX_PARITY_EN
            state_d     = PARITY;
            data_out_d  = parity_q;
`else
            state_d     = STOP;
            data_out_d  = 1'b1;
`endif
          end
        end
      end

`ifdef TX_PARITY_EN
      PARITY: begin
        if (sample_wrap) begin
          state_d    = STOP;
          data_out_d = 1'b1;
        end
      end
`endif

      STOP: begin
        if (sample_wrap) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          char_sent_d = 1'b1;
          data_out_d  = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        data_out_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Reset has priority over everything, so a load in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sample_count_q <= '0;
      bit_count_q    <= '0;
      shift_q        <= '0;
      data_out_q     <= 1'b1;
      busy_q         <= 1'b0;
      char_sent_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      bit_count_q    <= bit_count_d;
      shift_q        <= shift_d;
      data_out_q     <= data_out_d;
      busy_q         <= busy_d;
      char_sent_q    <= char_sent_d;
`ifdef TX_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign tx.data_out = data_out_q;
  assign tx.busy     = busy_q;
  assign tx.charSent = char_sent_q;

endmodule

// File: tb/tb_serial_transmitter.sv
`timescale 1ns/1ps
module tb_serial_transmitter;

  localparam int S  = 16;
  localparam int DB = 8;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * S;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_transmitter_if #(.DATA_BITS(DB)) tx_if ();

  serial_transmitter #(
    .SAMPLES_PER_BIT(S),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx(tx_if.slave)
  );

  typedef struct {
    logic [7:0] data;
    int         gap;   // required cycles since previous frame start, 0 = don't care
  } exp_t;

  exp_t sb_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit mon_en     = 1'b0;
  bit abort_flag = 1'b0;

  // monitor state
  bit   in_frame   = 1'b0;
  int   pos        = 0;
  int   busy_cnt   = 0;
  int   last_start = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hand-derived frame layout: 0, d[0..7], [even parity], 1
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Monitor: watches the line and pops expected characters from the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (abort_flag) begin
          in_frame   = 1'b0;
          abort_flag = 1'b0;
        end
        check("busy_charsent_exclusive", {31'd0, tx_if.busy & tx_if.charSent}, 32'd0);
        if (in_frame) begin
          pos++;
          if (pos < F) begin
            if (tx_if.busy === 1'b1) busy_cnt++;
            if (pos % S == S / 2)
              check($sformatf("bit%0d_of_%02h", pos / S, cur.data), {31'd0, tx_if.data_out},
                    {31'd0, frame_bit(cur.data, pos / S)});
          end else if (pos == F) begin
            check("busy_length", busy_cnt, F);
            check("busy_fall_at_F", {31'd0, tx_if.busy}, 32'd0);
            check("charsent_at_F", {31'd0, tx_if.charSent}, 32'd1);
          end else begin
            check("charsent_one_cycle", {31'd0, tx_if.charSent}, 32'd0);
            in_frame = 1'b0;
          end
        end
        if (!in_frame) begin
          if (tx_if.busy === 1'b1) begin
            check("start_bit_on_accept", {31'd0, tx_if.data_out}, 32'd0);
            if (sb_q.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_frame: frame started with no pending load (cycle %0d)", cyc);
              cur.data = 8'h00;
              cur.gap  = 0;
            end else begin
              cur = sb_q.pop_front();
            end
            if (cur.gap != 0) check("start_spacing", cyc - last_start, cur.gap);
            last_start = cyc;
            in_frame   = 1'b1;
            pos        = 0;
            busy_cnt   = 1;
          end else begin
            check("idle_line_high", {31'd0, tx_if.data_out}, 32'd1);
            check("idle_no_charsent", {31'd0, tx_if.charSent}, 32'd0);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.gap  = 0;
    sb_q.push_back(e);
    @(negedge clk);
    tx_if.load    = 1'b1;
    tx_if.data_in = d;
    @(posedge clk);
    #1;
    tx_if.load    = 1'b0;
    tx_if.data_in = 8'($urandom);
  endtask

  task automatic pulse_ignored(input logic [7:0] d);
    @(negedge clk);
    tx_if.load    = 1'b1;
    tx_if.data_in = d;
    @(posedge clk);
    #1;
    tx_if.load    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || tx_if.busy !== 1'b0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", {31'd0, n < budget}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    tx_if.load    = 1'b0;
    tx_if.data_in = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", {31'd0, tx_if.data_out}, 32'd1);
    check("reset_busy", {31'd0, tx_if.busy}, 32'd0);
    check("reset_charsent", {31'd0, tx_if.charSent}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // idle for 50 cycles
    repeat (50) @(negedge clk);

    // single frame
    send(8'hA5);
    wait_idle(F + 40);

    // back-to-back with load held high: second start 161 cycles after the first
    e.data = 8'h00; e.gap = 0;     sb_q.push_back(e);
    e.data = 8'hFF; e.gap = F + 1; sb_q.push_back(e);
    @(negedge clk);
    tx_if.load    = 1'b1;
    tx_if.data_in = 8'h00;
    @(posedge clk);
    #1;
    tx_if.data_in = 8'hFF;
    repeat (F + 1) @(posedge clk);
    #1;
    tx_if.load = 1'b0;
    wait_idle(2 * F + 40);

    // loads during a frame are ignored
    send(8'h3C);
    repeat (19) @(posedge clk);
    pulse_ignored(8'hC3);
    repeat (79) @(posedge clk);
    pulse_ignored(8'hFF);
    wait_idle(F + 40);

    // reset mid-frame at E+75
    send(8'h5A);
    repeat (74) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    abort_flag = 1'b1;
    @(negedge clk);
    check("abort_data_out", {31'd0, tx_if.data_out}, 32'd1);
    check("abort_busy", {31'd0, tx_if.busy}, 32'd0);
    repeat (F + 10) @(negedge clk);
    send(8'h81);
    wait_idle(F + 40);

    // parity test character (parity bit 1 when enabled)
    send(8'h07);
    wait_idle(F + 40);

    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Serial transmit engine that serialises one 8-bit character per request into an asynchronous frame on a single line. Frame: start bit, 8 data bits LSB first, stop bit; each bit held for a fixed number of clock cycles. It sits at the transmit end of the serial link and produces frames in the same 10-bit format and bit timing that the receive path samples. It pairs with the receive path for loopback testing.

## Interface
Parameters:
- SAMPLES_PER_BIT, 16: clock cycles each frame bit is held; must be ≥2.
- DATA_BITS, 8: data bits per character.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to send data_in; sampled every rising edge.
- data_in  input  DATA_BITS  character to send; captured only on an accepted load.
- data_out  output  1  serial line; registered; idles high.
- busy  output  1  high while a frame is in progress; registered.
- charSent  output  1  one-cycle pulse on frame completion; registered.

## Operation
- Clock is one clock, clk; reset is synchronous and active-high.
- States: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
- Counters: sampleCount, $clog2(SAMPLES_PER_BIT) bits, counts 0..SAMPLES_PER_BIT-1 and wraps to 0. bitCount, $clog2(DATA_BITS) bits, counts 0..DATA_BITS-1.
- IDLE:
  - data_out=1, busy=0.
  - load=1 latches data_in into the shift register, clears both counters, and enters START.
- START: data_out=0. When sampleCount wraps, go to DATA.
- DATA:
  - data_out = shift register bit 0.
  - When sampleCount wraps: shift right one place and increment bitCount.
  - When sampleCount wraps with bitCount=DATA_BITS-1, go to PARITY if enabled, else STOP.
- STOP:
  - data_out=1.
  - When sampleCount wraps: go to IDLE, busy←0, and charSent←1 for exactly one cycle.
- load while busy=1 is ignored. data_in changes during a frame have no effect.
- Reset values: data_out=1, busy=0, charSent=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame. data_out returns to 1 on the reset edge. No charSent pulse is produced for the aborted frame.
- reset and load in the same cycle: reset wins and the load is dropped.

## Timing
- load is accepted at edge E. At E: data_out→0 (start bit) and busy→1. Latency from load to first line transition is 1 cycle.
- Bit k (start = bit 0) occupies edges E+k·SAMPLES_PER_BIT through E+(k+1)·SAMPLES_PER_BIT−1.
- Frame length F = 10·SAMPLES_PER_BIT cycles (11·SAMPLES_PER_BIT with parity). With defaults, F = 160.
- At edge E+F: busy→0 and charSent→1. At edge E+F+1: charSent→0.
- A load asserted in the charSent cycle is accepted at E+F+1. This gives the minimum inter-frame idle of exactly 1 cycle of data_out=1 (the stop bit is extended by 1 cycle).
- busy and charSent are never high in the same cycle.

## Configuration
- TX_PARITY_EN:
  - Defined: PARITY state is inserted between DATA and STOP for SAMPLES_PER_BIT cycles. data_out = XOR of the latched data bits (even parity). Frame is 11 bits; F = 11·SAMPLES_PER_BIT.
  - Undefined: no PARITY state; frame is 10 bits. This is the format the receive path accepts.

## Test plan
- Reset, then idle for 50 cycles -> data_out=1, busy=0, charSent=0 throughout.
- load=1 for one cycle with data_in=8'hA5, SAMPLES_PER_BIT=16 -> line bits at sample midpoints are 0,1,0,1,0,0,1,0,1,1. busy is high for 160 cycles. charSent pulses once at E+160.
- Back-to-back sends: 8'h00, then 8'hFF with load held high -> second start bit falls exactly 161 cycles after the first. Both frames are correct.
- load pulses with a different data_in at E+20 and E+100 of an 8'h3C frame -> both ignored. Transmitted frame still carries 8'h3C.
- reset asserted at E+75 during 8'h5A -> data_out=1 and busy=0 at the next edge. No charSent. A new load of 8'h81 afterwards sends a correct complete frame.
- TX_PARITY_EN defined, data_in=8'h07 -> parity bit 1. Data bits are followed by stop. busy lasts 176 cycles.
